// File: rtl/obstacle_pkg.sv
// Shared definitions for the obstacle generator: type codes, image geometry,
// field positions inside the obstacle word and the FSM state encoding.
package obstacle_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GAP    = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam int COL_W  = 10;
  localparam int TYPE_W = 4;
  localparam int GAP_W  = 16;
  localparam int OBS_W  = 15;

  localparam int COL_LSB  = 0;
  localparam int COL_MSB  = 9;
  localparam int TYPE_LSB = 10;
  localparam int TYPE_MSB = 13;
  localparam int EN_BIT   = 14;

  localparam logic [TYPE_W-1:0] T_NONE   = 4'd0;
  localparam logic [TYPE_W-1:0] T_SMALL1 = 4'd1;
  localparam logic [TYPE_W-1:0] T_SMALL2 = 4'd2;
  localparam logic [TYPE_W-1:0] T_SMALL3 = 4'd3;
  localparam logic [TYPE_W-1:0] T_LARGE1 = 4'd5;
  localparam logic [TYPE_W-1:0] T_LARGE2 = 4'd6;
  localparam logic [TYPE_W-1:0] T_LARGE3 = 4'd7;
  localparam logic [TYPE_W-1:0] T_BIRD1  = 4'd9;
  localparam logic [TYPE_W-1:0] T_BIRD2  = 4'd10;
  localparam logic [TYPE_W-1:0] T_BIRD3  = 4'd11;

  localparam logic [COL_W-1:0] W_SMALL1 = 10'd17;
  localparam logic [COL_W-1:0] W_SMALL2 = 10'd34;
  localparam logic [COL_W-1:0] W_SMALL3 = 10'd51;
  localparam logic [COL_W-1:0] W_LARGE1 = 10'd25;
  localparam logic [COL_W-1:0] W_LARGE2 = 10'd50;
  localparam logic [COL_W-1:0] W_LARGE3 = 10'd75;
  localparam logic [COL_W-1:0] W_BIRD   = 10'd46;

  localparam logic [COL_W-1:0] H_SMALL = 10'd35;
  localparam logic [COL_W-1:0] H_LARGE = 10'd50;
  localparam logic [COL_W-1:0] H_BIRD  = 10'd40;

  function automatic logic [COL_W-1:0] type_width(input logic [TYPE_W-1:0] t);
    case (t)
      T_SMALL1: return W_SMALL1;
      T_SMALL2: return W_SMALL2;
      T_SMALL3: return W_SMALL3;
      T_LARGE1: return W_LARGE1;
      T_LARGE2: return W_LARGE2;
      T_LARGE3: return W_LARGE3;
      T_BIRD1, T_BIRD2, T_BIRD3: return W_BIRD;
      default:  return '0;
    endcase
  endfunction

endpackage

// File: rtl/obstacle_lfsr.sv
// 16-bit Fibonacci LFSR, taps 16,14,13,11, shifting right; advances on step.
module obstacle_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  output logic [15:0] q
);

  logic fb;
  assign fb = q[0] ^ q[2] ^ q[3] ^ q[5];

  always_ff @(posedge clk) begin
    if (rst)       q <= SEED;
    else if (step) q <= {fb, q[15:1]};
  end

endmodule

// File: rtl/obstacle_gen.sv
// Obstacle spawner/scroller: IDLE -> GAP (random wait) -> ACTIVE (scroll left).
// Define OBSTACLE_BIRD_EN to allow bird types 9-11; otherwise they fold to large cacti.
module obstacle_gen
  import obstacle_pkg::*;
#(
  parameter int          SCREEN_W  = 640,
  parameter int          MIN_GAP   = 40,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             game_tick,
  input  logic             run,
  input  logic             freeze,
  input  logic [3:0]       speed,
  output logic [OBS_W-1:0] obstacle,
  output logic             passed
);

  state_t             state, state_nx;
  logic [GAP_W-1:0]   gap_cnt, gap_nx;
  logic [OBS_W-1:0]   obstacle_nx;
  logic               passed_nx;
  logic [15:0]        lfsr;
  logic               lfsr_unused;
  logic               adv;
  logic               retire;
  logic [COL_W-1:0]   col;
  logic [COL_W-1:0]   eff_speed;
  logic [GAP_W-1:0]   fresh_gap;
  logic [1:0]         n;
  logic [TYPE_W-1:0]  new_type;
  logic [COL_W-1:0]   new_col;

  assign adv         = game_tick & ~freeze;
  assign col         = obstacle[COL_MSB:COL_LSB];
  assign eff_speed   = (speed == 4'd0) ? 10'd1 : {6'd0, speed};
  // compare before subtracting so col can never wrap below zero
  assign retire      = (col <= eff_speed);
  assign fresh_gap   = GAP_W'(MIN_GAP) + GAP_W'(lfsr[8:4]);
  assign n           = (lfsr[3:2] == 2'd0) ? 2'd1 : lfsr[3:2];
  assign new_col     = COL_W'(SCREEN_W) + type_width(new_type);
  assign lfsr_unused = ^lfsr[15:9];

  always_comb begin
    case (lfsr[1:0])
      2'b01:   new_type = 4'd4 + {2'b00, n};
`ifdef OBSTACLE_BIRD_EN
      2'b11:   new_type = 4'd8 + {2'b00, n};
`else
      2'b11:   new_type = 4'd4 + {2'b00, n};
`endif
      default: new_type = {2'b00, n};
    endcase
  end

  obstacle_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .step (run & adv),
    .q    (lfsr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gap_cnt  <= '0;
      obstacle <= '0;
      passed   <= 1'b0;
    end else begin
      state    <= state_nx;
      gap_cnt  <= gap_nx;
      obstacle <= obstacle_nx;
      passed   <= passed_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (!run) state_nx = IDLE;
    else begin
      case (state)
        IDLE:    state_nx = GAP;
        GAP:     if (adv && gap_cnt <= GAP_W'(1)) state_nx = ACTIVE;
        ACTIVE:  if (adv && retire) state_nx = GAP;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    gap_nx      = gap_cnt;
    obstacle_nx = obstacle;
    passed_nx   = 1'b0;
    if (!run) begin
      gap_nx      = '0;
      obstacle_nx = '0;
    end else begin
      case (state)
        IDLE: begin
          gap_nx      = fresh_gap;
          obstacle_nx = '0;
        end
        GAP: if (adv) begin
          if (gap_cnt <= GAP_W'(1)) begin
            gap_nx                        = '0;
            obstacle_nx[EN_BIT]           = 1'b1;
            obstacle_nx[TYPE_MSB:TYPE_LSB] = new_type;
            obstacle_nx[COL_MSB:COL_LSB]   = new_col;
          end else begin
            gap_nx = gap_cnt - GAP_W'(1);
          end
        end
        ACTIVE: if (adv) begin
          if (retire) begin
            obstacle_nx = '0;
            passed_nx   = 1'b1;
            gap_nx      = fresh_gap;
          end else begin
            obstacle_nx[COL_MSB:COL_LSB] = col - eff_speed;
          end
        end
        default: obstacle_nx = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_obstacle_gen.sv
// Directed bench for obstacle_gen: reset, spawn, scroll, freeze, retire, run drop, bird select.
module tb_obstacle_gen;
  import obstacle_pkg::*;

  logic        clk = 1'b0;
  logic        rst, game_tick, run, freeze;
  logic [3:0]  speed;
  logic [14:0] obstacle;
  logic        passed;

  int          pass_cnt = 0;
  int          total    = 0;
  logic [15:0] m_lfsr;
  logic [9:0]  m_col;
  int          m_gap;

  always #5 clk = ~clk;

  obstacle_gen #(.SCREEN_W(640), .MIN_GAP(2), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .game_tick(game_tick), .run(run), .freeze(freeze),
    .speed(speed), .obstacle(obstacle), .passed(passed)
  );

  function automatic logic [15:0] lnext(input logic [15:0] q);
    return {q[0] ^ q[2] ^ q[3] ^ q[5], q[15:1]};
  endfunction

  function automatic logic [3:0] exp_type(input logic [15:0] v);
    logic [3:0] nn;
    nn = (v[3:2] == 2'd0) ? 4'd1 : {2'b00, v[3:2]};
    case (v[1:0])
      2'b01:   return 4'd4 + nn;
`ifdef OBSTACLE_BIRD_EN
      2'b11:   return 4'd8 + nn;
`else
      2'b11:   return 4'd4 + nn;
`endif
      default: return nn;
    endcase
  endfunction

  function automatic logic [9:0] exp_width(input logic [3:0] t);
    case (t)
      4'd1: return 10'd17;
      4'd2: return 10'd34;
      4'd3: return 10'd51;
      4'd5: return 10'd25;
      4'd6: return 10'd50;
      4'd7: return 10'd75;
      4'd9, 4'd10, 4'd11: return 10'd46;
      default: return 10'd0;
    endcase
  endfunction

  // one tick pulse; returns at the negedge after the consuming posedge
  task automatic tick(input logic [3:0] spd);
    speed = spd; game_tick = 1'b1;
    @(negedge clk);
    game_tick = 1'b0;
    if (run && !freeze) m_lfsr = lnext(m_lfsr);
  endtask

  task automatic move(input logic [3:0] spd);
    logic [9:0] e;
    e = (spd == 4'd0) ? 10'd1 : {6'd0, spd};
    tick(spd);
    m_col = m_col - e;
    total++;
    if (obstacle[9:0] !== m_col) $display("FAIL move_col got %0d want %0d", obstacle[9:0], m_col);
    else pass_cnt++;
    repeat (3) @(negedge clk);
  endtask

  task automatic drive_to(input logic [9:0] target);
    while (m_col - target > 10'd15) move(4'd15);
    if (m_col > target) move(4'(m_col - target));
  endtask

  // run through a gap of g ticks and check the spawned obstacle
  task automatic run_gap(input int g, input string name);
    logic [15:0] v;
    logic [3:0]  t;
    logic [14:0] want;
    v = m_lfsr;
    for (int i = 1; i <= g; i++) begin
      v = m_lfsr;
      tick(4'd1);
      if (i == g - 1) begin
        total++;
        if (obstacle[14] !== 1'b0) $display("FAIL %s_early_en got %b want 0", name, obstacle[14]);
        else pass_cnt++;
      end
      if (i < g) repeat (3) @(negedge clk);
    end
    t = exp_type(v);
    want = {1'b1, t, 10'd640 + exp_width(t)};
    total++;
    if (obstacle !== want) $display("FAIL %s_spawn got %h want %h", name, obstacle, want);
    else pass_cnt++;
    m_col = want[9:0];
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; run = 1'b0; freeze = 1'b0; game_tick = 1'b0; speed = 4'd0;
    repeat (3) @(negedge clk);
    total++;
    if (obstacle !== 15'h0000) $display("FAIL reset_obstacle got %h want 0000", obstacle);
    else pass_cnt++;
    total++;
    if (passed !== 1'b0) $display("FAIL reset_passed got %b want 0", passed);
    else pass_cnt++;
    total++;
    if (dut.u_lfsr.q !== 16'hACE1) $display("FAIL reset_lfsr got %h want ace1", dut.u_lfsr.q);
    else pass_cnt++;
    rst = 1'b0;
    m_lfsr = 16'hACE1;
    tick(4'd1);
    total++;
    if (dut.u_lfsr.q !== 16'hACE1) $display("FAIL idle_lfsr_hold got %h want ace1", dut.u_lfsr.q);
    else pass_cnt++;
    total++;
    if (dut.state !== IDLE) $display("FAIL idle_state got %0d want %0d", dut.state, IDLE);
    else pass_cnt++;
  endtask

  task automatic test_spawn;
    run = 1'b1;
    @(negedge clk);
    total++;
    if (dut.gap_cnt !== 16'd16) $display("FAIL gap_load got %0d want 16", dut.gap_cnt);
    else pass_cnt++;
    tick(4'd1);
    total++;
    if (dut.u_lfsr.q !== 16'h5670) $display("FAIL lfsr_step got %h want 5670", dut.u_lfsr.q);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    run_gap(15, "first");
  endtask

  task automatic test_freeze;
    logic [15:0] l0;
    drive_to(10'd200);
    freeze = 1'b1;
    l0 = dut.u_lfsr.q;
    for (int i = 0; i < 5; i++) begin
      tick(4'd4);
      repeat (3) @(negedge clk);
    end
    total++;
    if (obstacle[9:0] !== 10'd200) $display("FAIL freeze_col got %0d want 200", obstacle[9:0]);
    else pass_cnt++;
    total++;
    if (dut.u_lfsr.q !== l0) $display("FAIL freeze_lfsr got %h want %h", dut.u_lfsr.q, l0);
    else pass_cnt++;
    freeze = 1'b0;
    tick(4'd4);
    total++;
    if (obstacle[9:0] !== 10'd196) $display("FAIL unfreeze_col got %0d want 196", obstacle[9:0]);
    else pass_cnt++;
    m_col = 10'd196;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_move;
    drive_to(10'd100);
    tick(4'd4);
    total++;
    if (obstacle[9:0] !== 10'd96) $display("FAIL move4_col got %0d want 96", obstacle[9:0]);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if (obstacle[9:0] !== 10'd96) $display("FAIL move4_hold got %0d want 96", obstacle[9:0]);
    else pass_cnt++;
    tick(4'd0);
    total++;
    if (obstacle[9:0] !== 10'd95) $display("FAIL speed0_col got %0d want 95", obstacle[9:0]);
    else pass_cnt++;
    m_col = 10'd95;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_retire;
    logic [15:0] v;
    drive_to(10'd3);
    v = m_lfsr;
    tick(4'd4);
    m_gap = 2 + int'(v[8:4]);
    total++;
    if (obstacle !== 15'h0000) $display("FAIL retire_obstacle got %h want 0000", obstacle);
    else pass_cnt++;
    total++;
    if (passed !== 1'b1) $display("FAIL retire_passed got %b want 1", passed);
    else pass_cnt++;
    total++;
    if (dut.state !== GAP) $display("FAIL retire_state got %0d want %0d", dut.state, GAP);
    else pass_cnt++;
    total++;
    if (dut.gap_cnt !== 16'(m_gap)) $display("FAIL retire_gap got %0d want %0d", dut.gap_cnt, m_gap);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if (passed !== 1'b0) $display("FAIL passed_width got %b want 0", passed);
    else pass_cnt++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_run_low;
    run_gap(m_gap, "second");
    run = 1'b0;
    @(negedge clk);
    total++;
    if (obstacle !== 15'h0000 || passed !== 1'b0)
      $display("FAIL run_low got obs=%h passed=%b want 0000/0", obstacle, passed);
    else pass_cnt++;
    total++;
    if (dut.state !== IDLE) $display("FAIL run_low_state got %0d want %0d", dut.state, IDLE);
    else pass_cnt++;
    run = 1'b1;
    @(negedge clk);
    tick(4'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; run = 1'b0;
    total++;
    if (dut.state !== IDLE || dut.u_lfsr.q !== 16'hACE1 || obstacle !== 15'h0000)
      $display("FAIL rst_mid_gap got state=%0d lfsr=%h obs=%h want 0/ace1/0000",
               dut.state, dut.u_lfsr.q, obstacle);
    else pass_cnt++;
    m_lfsr = 16'hACE1;
    @(negedge clk);
  endtask

  task automatic test_bird;
    logic [15:0] qk, v;
    logic [3:0]  t;
    int          k, g;
    k = 0;
    qk = m_lfsr;
    for (int i = 0; i < 200; i++) begin
      g = 2 + int'(qk[8:4]);
      v = qk;
      for (int j = 1; j < g; j++) v = lnext(v);
      if (v[1:0] == 2'b11) break;
      qk = lnext(qk);
      k++;
    end
    for (int i = 0; i < k; i++) begin
      run = 1'b1; game_tick = 1'b1;
      @(negedge clk);
      run = 1'b0; game_tick = 1'b0;
      m_lfsr = lnext(m_lfsr);
      @(negedge clk);
    end
    run = 1'b1;
    @(negedge clk);
    run_gap(2 + int'(m_lfsr[8:4]), "bird");
    t = obstacle[13:10];
    total++;
`ifdef OBSTACLE_BIRD_EN
    if (t < 4'd9 || t > 4'd11 || obstacle[9:0] !== 10'd686)
      $display("FAIL bird_sel got type=%0d col=%0d want 9-11/686", t, obstacle[9:0]);
    else pass_cnt++;
`else
    if (t < 4'd5 || t > 4'd7)
      $display("FAIL bird_fold got type=%0d want 5-7", t);
    else pass_cnt++;
`endif
  endtask

  initial begin
    test_reset;
    test_spawn;
    test_freeze;
    test_move;
    test_retire;
    test_run_low;
    test_bird;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/obstacle_gen.md
OBSTACLE_GEN -- requirements
Module: obstacle_gen

Interface
REQ-001 SHALL have parameter SCREEN_W, default 640, visible columns.
REQ-002 SHALL have parameter MIN_GAP, default 40, minimum game ticks between obstacles.
REQ-003 SHALL have parameter LFSR_SEED, default 16'hACE1, non-zero LFSR reset value.
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port game_tick  input  1  one-clk-wide pulse per game step, synchronous to clk.
REQ-007 SHALL have port run  input  1  game active; low forces IDLE.
REQ-008 SHALL have port freeze  input  1  collision hold; obstacle stays put while high.
REQ-009 SHALL have port speed  input  4  pixels moved per tick; 0 treated as 1.
REQ-010 SHALL have port obstacle  output  15  {en[14], type[13:10], col[9:0]}, col = right edge + 1 of image, registered.
REQ-011 SHALL have port passed  output  1  one-clk pulse when an obstacle retires off the left edge.

Function
REQ-012 SHALL implement states IDLE, GAP, ACTIVE; state and all outputs change only on clk edges.
REQ-013 IDLE: en=0, type=0, col=0; on run=1 go to GAP with gap counter = MIN_GAP + lfsr[8:4].
REQ-014 GAP: counter decrements by 1 on each game_tick with freeze=0; on the tick it reaches 0, spawn and go to ACTIVE the next cycle.
REQ-015 Spawn: type from the LFSR value at that tick: n = (lfsr[3:2]==0) ? 1 : lfsr[3:2]; lfsr[1:0] 00/10 -> small (n), 01 -> large (4+n), 11 -> bird (8+n).
REQ-016 Spawn col = SCREEN_W + width(type); widths small 17/34/51, large 25/50/75, bird 46; en=1.
REQ-017 ACTIVE: on game_tick with freeze=0, col <= col - eff_speed, visible one cycle after the tick.
REQ-018 Retire: if col <= eff_speed at a tick, the same update sets en=0, type=0, col=0, pulses passed for exactly one cycle, and enters GAP with a fresh gap count.
REQ-019 freeze=1 blocks all col, gap counter and LFSR updates; freeze and game_tick together means freeze wins.
REQ-020 run=0 in any state means IDLE next cycle, en=0, no passed pulse.
REQ-021 LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances once per unfrozen game_tick while run=1.
REQ-022 Arithmetic SHALL be 10-bit unsigned; retire check precedes subtraction so col never wraps.

Reset
REQ-023 On rst: state=IDLE, obstacle=15'h0000, passed=0, gap counter=0, LFSR=LFSR_SEED.
REQ-024 rst SHALL override run, freeze and game_tick in the same cycle, including mid-GAP and mid-ACTIVE.

Configuration
REQ-025 Macro OBSTACLE_BIRD_EN defined: lfsr[1:0]=11 yields bird types 9/10/11.
REQ-026 Macro OBSTACLE_BIRD_EN undefined: lfsr[1:0]=11 yields large cactus (4+n); type values 9-11 never appear.

Structure
REQ-027 Package obstacle_pkg SHALL hold type codes (0,1-3,5-7,9-11), image widths/heights, the field bit positions of obstacle, and the state enum.
REQ-028 LFSR SHALL be a sub-module obstacle_lfsr (clk, rst, step, q[15:0]); all other logic stays in obstacle_gen.

Verification
REQ-029 rst, then run=1, MIN_GAP=2, seed ACE1, ticks every 4 clk -> en rises after 2+lfsr[8:4] ticks; col = 640+width(type) on spawn.
REQ-030 ACTIVE col=100, speed=4, one tick -> col=96 exactly one clk later; speed=0 -> col=99.
REQ-031 col=3, speed=4, tick -> en=0, passed high 1 clk, state GAP.
REQ-032 freeze=1 across 5 ticks at col=200 -> col stays 200, LFSR unchanged; release, 1 tick -> col=196.
REQ-033 run=0 mid-ACTIVE -> obstacle=0 next clk, no passed; rst mid-GAP -> IDLE, LFSR=ACE1.
REQ-034 Force lfsr[1:0]=11 at spawn: with OBSTACLE_BIRD_EN -> type 9-11, col=686; without -> type 5-7.
